psx_packet_dispatcher: RTL and testbench
========================================

// Module: psx_packet_dispatcher
// PURPOSE
//  Parses the serial controller-state packet stream from serial_rx and routes payload writes to NUM_PORTS psx_controller instances.
//  Sits between serial_rx and the controller emulators.
//  Replaces single-port glue with per-slot write enables, size decode and error accounting.
// PARAMETERS
//  NUM_PORTS    2     number of controller slots; write_en width; max 16
//  HDR_NIBBLE   4'h5  required value of header byte [7:4]
//  MAX_PAYLOAD  18    largest payload in bytes; sets checksum buffer depth
// PORTS
//  clk          in   1          system clock (FX2 IFCLK domain)
//  reset        in   1          synchronous, active-high
//  rx_data      in   8          received byte; valid with rx_strobe
//  rx_strobe    in   1          one-cycle pulse per received byte
//  rx_idle      in   1          line idle; aborts any packet in progress
//  write_addr   out  5          payload byte index, 0..MAX_PAYLOAD-1
//  write_data   out  8          payload byte
//  write_en     out  NUM_PORTS  one-hot, one-cycle write strobe to slot
//  pkt_done     out  1          one-cycle pulse: packet fully applied
//  pkt_error    out  1          one-cycle pulse: packet rejected or aborted
//  error_count  out  8          saturating count of pkt_error pulses
//  busy         out  1          high in any state other than S_HDR
// BEHAVIOUR
//  - Reset values: all outputs 0; state S_HDR.
//  - Frame format: header byte {HDR_NIBBLE, port[3:0]}, then flags byte, then payload.
//  - Payload length from flags: [2] -> 18, else [1] -> 6, else [0] -> 2, else 0. Highest set bit wins.
//  - FSM states and transitions:
//    - S_HDR: on strobe, if data[7:4] != HDR_NIBBLE go to S_SKIP and pulse pkt_error; else latch port and go to S_FLAGS.
//    - S_FLAGS: latch length. If length 0, pulse pkt_done next cycle and go to S_HDR; else go to S_DATA.
//    - S_DATA: each strobe writes one byte. On the last byte go to S_HDR (or S_CHK when checksum is enabled).
//    - S_SKIP: ignore all strobes until rx_idle.
//  - Write timing: write_en[port], write_addr, write_data are registered, one cycle after the data rx_strobe, held for 1 cycle.
//  - Addresses run 0..len-1 in arrival order.
//  - pkt_done is coincident with the final write_en.
//  - Port >= NUM_PORTS: packet is parsed normally, write_en stays 0, and pkt_error pulses in place of pkt_done.
//  - rx_idle has priority over rx_strobe in the same cycle.
//    - Idle in S_FLAGS/S_DATA/S_CHK: go to S_HDR and pulse pkt_error. Writes already issued are not undone.
//    - Idle in S_HDR/S_SKIP: go to S_HDR, no error.
//  - error_count increments on every pkt_error pulse and saturates at 8'hFF. Cleared only by reset.
//  - Reset mid-packet: state to S_HDR, all strobes drop the same edge, no pulse.
// CONFIGURATION
//  PSX_PKT_CHECKSUM_EN defined:
//    - A checksum byte follows the payload.
//    - Packet is valid iff the mod-256 sum of header + flags + payload + checksum == 8'h00.
//    - Payload is staged in a buffer; no write_en occurs during S_DATA.
//    - S_CHK on checksum strobe:
//      - Pass: S_REPLAY emits one write per cycle, addr 0..len-1, starting the cycle after the checksum strobe. pkt_done is on the last write.
//      - Fail: pulse pkt_error, go to S_HDR, no writes.
//    - Length-0 packets also require the checksum byte.
//    - rx_strobe during S_REPLAY: byte dropped, pkt_error pulses, replay completes.
//  PSX_PKT_CHECKSUM_EN undefined: no checksum byte, no buffer, writes are streamed as described above.
// STRUCTURE
//  - psx_dispatch_defs.vh: state encodings (S_HDR, S_FLAGS, S_DATA, S_CHK, S_REPLAY, S_SKIP), HDR_NIBBLE default, length-decode constants. Shared with the future upstream packet builder.
//  - Sub-module psx_payload_buffer: MAX_PAYLOAD x 8 register file, 1 write / 1 read port. Instantiated only under PSX_PKT_CHECKSUM_EN.
// TESTING
//  1. Stream 51 01 AA BB -> write_en=2'b10: addr0=AA, then addr1=BB; pkt_done with 2nd write; error_count=0.
//  2. Stream 50 04 + 18 bytes 00..11 -> 18 writes to slot 0, addr==data; single pkt_done.
//  3. Stream 60 01 AA BB, then idle, then 50 00 -> pkt_error once, no writes; then pkt_done; error_count=1.
//  4. Stream 50 02 11 22, then idle with rx_strobe in the same cycle -> 2 writes, pkt_error, state S_HDR, error_count=1.
//  5. Stream 53 01 AA BB with NUM_PORTS=2 -> no write_en, pkt_error; 256 such packets -> error_count=FF.
//  6. CHECKSUM_EN: stream 50 01 10 20 7F -> 2 back-to-back writes after checksum. Same with checksum 7E -> pkt_error, no writes.

Source files
------------

// File: rtl/psx_packet_dispatcher_pkg.sv
// rtl/psx_packet_dispatcher_pkg.sv - dispatcher state encodings, header default and payload-length decode
package psx_packet_dispatcher_pkg;

  typedef enum logic [2:0] {
    S_HDR    = 3'd0,
    S_FLAGS  = 3'd1,
    S_DATA   = 3'd2,
    S_CHK    = 3'd3,
    S_REPLAY = 3'd4,
    S_SKIP   = 3'd5
  } state_t;

  localparam logic [3:0] HDR_NIBBLE_DEFAULT = 4'h5;

  localparam logic [4:0] LEN_FLAG2 = 5'd18;
  localparam logic [4:0] LEN_FLAG1 = 5'd6;
  localparam logic [4:0] LEN_FLAG0 = 5'd2;
  localparam logic [4:0] LEN_NONE  = 5'd0;

  // Highest set flag bit selects the payload size.
  function automatic logic [4:0] decode_len(input logic [2:0] flags);
    if (flags[2]) return LEN_FLAG2;
    else if (flags[1]) return LEN_FLAG1;
    else if (flags[0]) return LEN_FLAG0;
    else return LEN_NONE;
  endfunction

endpackage

// File: rtl/psx_payload_buffer.sv
// rtl/psx_payload_buffer.sv - payload staging register file, one write and one asynchronous read port
module psx_payload_buffer #(
  parameter int DEPTH = 18,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/psx_packet_dispatcher.sv
// rtl/psx_packet_dispatcher.sv - serial packet parser routing payload writes to controller slots; option PSX_PKT_CHECKSUM_EN
module psx_packet_dispatcher
  import psx_packet_dispatcher_pkg::*;
#(
  parameter int         NUM_PORTS   = 2,
  parameter logic [3:0] HDR_NIBBLE  = HDR_NIBBLE_DEFAULT,
  parameter int         MAX_PAYLOAD = 18
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           rx_data,
  input  logic                 rx_strobe,
  input  logic                 rx_idle,
  output logic [4:0]           write_addr,
  output logic [7:0]           write_data,
  output logic [NUM_PORTS-1:0] write_en,
  output logic                 pkt_done,
  output logic                 pkt_error,
  output logic [7:0]           error_count,
  output logic                 busy
);

  state_t               state, state_n;
  logic [3:0]           port_q, port_n;
  logic [4:0]           len_q, len_n;
  logic [4:0]           cnt_q, cnt_n;
  logic [NUM_PORTS-1:0] wen_n;
  logic [4:0]           waddr_n;
  logic [7:0]           wdata_n;
  logic                 done_n, err_n;
  logic                 port_ok;
  logic [NUM_PORTS-1:0] port_sel;
  logic                 last_byte;
  logic [4:0]           len_dec;

  assign port_ok   = ({1'b0, port_q} < 5'(NUM_PORTS));
  assign port_sel  = port_ok ? (NUM_PORTS'(1) << port_q) : '0;
  assign last_byte = (cnt_q == len_q - 5'd1);
  // Never let a flags byte describe more payload than the slot can hold.
  assign len_dec   = (decode_len(rx_data[2:0]) > 5'(MAX_PAYLOAD)) ? 5'(MAX_PAYLOAD)
                                                                   : decode_len(rx_data[2:0]);
  assign busy      = (state != S_HDR);

`ifdef PSX_PKT_CHECKSUM_EN
  logic [7:0] sum_q, sum_n;
  logic       buf_we;
  logic [4:0] buf_raddr;
  logic [7:0] buf_rdata;

  // The checksum cycle already emits entry 0, replay reads the rest.
  assign buf_raddr = (state == S_CHK) ? 5'd0 : cnt_q;

  psx_payload_buffer #(
    .DEPTH (MAX_PAYLOAD),
    .AW    (5)
  ) u_payload_buffer (
    .clk     (clk),
    .wr_en   (buf_we),
    .wr_addr (cnt_q),
    .wr_data (rx_data),
    .rd_addr (buf_raddr),
    .rd_data (buf_rdata)
  );
`endif

  always_comb begin
    state_n = state;
    port_n  = port_q;
    len_n   = len_q;
    cnt_n   = cnt_q;
    wen_n   = '0;
    waddr_n = '0;
    wdata_n = '0;
    done_n  = 1'b0;
    err_n   = 1'b0;
`ifdef PSX_PKT_CHECKSUM_EN
    sum_n   = sum_q;
    buf_we  = 1'b0;
`endif
    case (state)
      S_HDR: begin
        if (!rx_idle && rx_strobe) begin
          if (rx_data[7:4] != HDR_NIBBLE) begin
            err_n   = 1'b1;
            state_n = S_SKIP;
          end else begin
            port_n  = rx_data[3:0];
            state_n = S_FLAGS;
`ifdef PSX_PKT_CHECKSUM_EN
            sum_n   = rx_data;
`endif
          end
        end
      end
      S_FLAGS: begin
        if (rx_idle) begin
          err_n   = 1'b1;
          state_n = S_HDR;
        end else if (rx_strobe) begin
          len_n = len_dec;
          cnt_n = '0;
`ifdef PSX_PKT_CHECKSUM_EN
          sum_n   = sum_q + rx_data;
          state_n = (len_dec == 5'd0) ? S_CHK : S_DATA;
`else
          if (len_dec == 5'd0) begin
            done_n  = port_ok;
            err_n   = !port_ok;
            state_n = S_HDR;
          end else begin
            state_n = S_DATA;
          end
`endif
        end
      end
      S_DATA: begin
        if (rx_idle) begin
          err_n   = 1'b1;
          state_n = S_HDR;
        end else if (rx_strobe) begin
          cnt_n = cnt_q + 5'd1;
`ifdef PSX_PKT_CHECKSUM_EN
          buf_we = 1'b1;
          sum_n  = sum_q + rx_data;
          if (last_byte) state_n = S_CHK;
`else
          wen_n   = port_sel;
          waddr_n = cnt_q;
          wdata_n = rx_data;
          if (last_byte) begin
            done_n  = port_ok;
            err_n   = !port_ok;
            state_n = S_HDR;
          end
`endif
        end
      end
`ifdef PSX_PKT_CHECKSUM_EN
      S_CHK: begin
        if (rx_idle) begin
          err_n   = 1'b1;
          state_n = S_HDR;
        end else if (rx_strobe) begin
          if (8'(sum_q + rx_data) != 8'h00) begin
            err_n   = 1'b1;
            state_n = S_HDR;
          end else if (len_q == 5'd0) begin
            done_n  = port_ok;
            err_n   = !port_ok;
            state_n = S_HDR;
          end else begin
            wen_n   = port_sel;
            waddr_n = 5'd0;
            wdata_n = buf_rdata;
            cnt_n   = 5'd1;
            state_n = S_REPLAY;
          end
        end
      end
      S_REPLAY: begin
        wen_n   = port_sel;
        waddr_n = cnt_q;
        wdata_n = buf_rdata;
        cnt_n   = cnt_q + 5'd1;
        if (last_byte) begin
          done_n  = port_ok;
          err_n   = !port_ok;
          state_n = S_HDR;
        end
        // Bytes arriving while the buffer drains are lost.
        if (rx_strobe) err_n = 1'b1;
      end
`endif
      S_SKIP: begin
        if (rx_idle) state_n = S_HDR;
      end
      default: state_n = S_HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_HDR;
      port_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      write_en    <= '0;
      write_addr  <= '0;
      write_data  <= '0;
      pkt_done    <= 1'b0;
      pkt_error   <= 1'b0;
      error_count <= '0;
`ifdef PSX_PKT_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state      <= state_n;
      port_q     <= port_n;
      len_q      <= len_n;
      cnt_q      <= cnt_n;
      write_en   <= wen_n;
      write_addr <= waddr_n;
      write_data <= wdata_n;
      pkt_done   <= done_n;
      pkt_error  <= err_n;
      if (err_n && error_count != 8'hFF) error_count <= error_count + 8'd1;
`ifdef PSX_PKT_CHECKSUM_EN
      sum_q      <= sum_n;
`endif
    end
  end

endmodule

// File: tb/tb_psx_packet_dispatcher.sv
// tb/tb_psx_packet_dispatcher.sv - randomized bench for psx_packet_dispatcher against a packet-level reference model
module tb_psx_packet_dispatcher;

  localparam int NP   = 2;
  localparam int NCYC = 65536;
`ifdef PSX_PKT_CHECKSUM_EN
  localparam bit CKS = 1'b1;
`else
  localparam bit CKS = 1'b0;
`endif

  localparam int P_HDR = 0, P_FLAGS = 1, P_DATA = 2, P_CHK = 3, P_SKIP = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_strobe = 1'b0;
  logic          rx_idle = 1'b0;
  logic [4:0]    write_addr;
  logic [7:0]    write_data;
  logic [NP-1:0] write_en;
  logic          pkt_done, pkt_error, busy;
  logic [7:0]    error_count;

  psx_packet_dispatcher #(.NUM_PORTS(NP)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_strobe   (rx_strobe),
    .rx_idle     (rx_idle),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .write_en    (write_en),
    .pkt_done    (pkt_done),
    .pkt_error   (pkt_error),
    .error_count (error_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs, indexed by the clock edge after which they must be visible.
  bit [NP-1:0] e_wen  [NCYC];
  bit [4:0]    e_addr [NCYC];
  bit [7:0]    e_data [NCYC];
  bit          e_done [NCYC];
  bit          e_err  [NCYC];
  bit          e_busy [NCYC];
  bit          e_rst  [NCYC];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: actual %0h required %0h", name, cyc, act, req);
    end
  endtask

  // Reference parser state.
  int       ph = P_HDR;
  int       m_port = 0, m_len = 0, m_got = 0, m_sum = 0, m_rlast = -1;
  bit [7:0] m_pay [18];

  function automatic int plen(input logic [7:0] f);
    if (f[2]) return 18;
    if (f[1]) return 6;
    if (f[0]) return 2;
    return 0;
  endfunction

  task automatic finish_at(input int t);
    if (m_port < NP) e_done[t] = 1'b1;
    else e_err[t] = 1'b1;
  endtask

  task automatic model(input int k, input bit r, input bit s, input logic [7:0] d, input bit i);
    if (r) begin
      for (int t = k + 1; t <= k + 25; t++) begin
        e_wen[t] = '0; e_addr[t] = '0; e_data[t] = '0;
        e_done[t] = 1'b0; e_err[t] = 1'b0; e_busy[t] = 1'b0;
      end
      e_rst[k+1] = 1'b1;
      ph = P_HDR;
      m_rlast = -1;
      return;
    end
    if (k <= m_rlast) begin
      if (s) e_err[k+1] = 1'b1;
      e_busy[k+1] = (k < m_rlast);
      return;
    end
    case (ph)
      P_HDR: if (!i && s) begin
        if (d[7:4] != 4'h5) begin
          e_err[k+1] = 1'b1;
          ph = P_SKIP;
        end else begin
          m_port = int'(d[3:0]);
          m_sum = int'(d);
          ph = P_FLAGS;
        end
      end
      P_FLAGS: if (i) begin
        e_err[k+1] = 1'b1;
        ph = P_HDR;
      end else if (s) begin
        m_len = plen(d);
        m_sum += int'(d);
        m_got = 0;
        if (m_len > 0) ph = P_DATA;
        else if (CKS) ph = P_CHK;
        else begin
          finish_at(k + 1);
          ph = P_HDR;
        end
      end
      P_DATA: if (i) begin
        e_err[k+1] = 1'b1;
        ph = P_HDR;
      end else if (s) begin
        if (CKS) begin
          m_pay[m_got] = d;
          m_sum += int'(d);
        end else if (m_port < NP) begin
          e_wen[k+1]  = NP'(1) << m_port;
          e_addr[k+1] = 5'(m_got);
          e_data[k+1] = d;
        end
        m_got++;
        if (m_got == m_len) begin
          if (CKS) ph = P_CHK;
          else begin
            finish_at(k + 1);
            ph = P_HDR;
          end
        end
      end
      P_CHK: if (i) begin
        e_err[k+1] = 1'b1;
        ph = P_HDR;
      end else if (s) begin
        if (((m_sum + int'(d)) % 256) == 0) begin
          if (m_len == 0) finish_at(k + 1);
          else begin
            for (int j = 0; j < m_len; j++) begin
              if (m_port < NP) begin
                e_wen[k+1+j]  = NP'(1) << m_port;
                e_addr[k+1+j] = 5'(j);
                e_data[k+1+j] = m_pay[j];
              end
            end
            finish_at(k + m_len);
            m_rlast = k + m_len - 1;
          end
        end else begin
          e_err[k+1] = 1'b1;
        end
        ph = P_HDR;
      end
      P_SKIP: if (i) ph = P_HDR;
      default: ph = P_HDR;
    endcase
    e_busy[k+1] = (ph != P_HDR) || (k < m_rlast);
  endtask

  typedef struct {
    int          c;
    bit [NP-1:0] wen;
    bit [4:0]    a;
    bit [7:0]    d;
  } wr_t;
  wr_t wlog[$];
  int  n_done = 0, n_err = 0;
  int  mec = 0;

  always @(negedge clk) begin
    if (cyc >= 1 && cyc < NCYC) begin
      if (e_rst[cyc]) mec = 0;
      else if (e_err[cyc] && mec != 255) mec++;
      check("write_en", 32'(write_en), 32'(e_wen[cyc]));
      if (e_wen[cyc] != '0) begin
        check("write_addr", 32'(write_addr), 32'(e_addr[cyc]));
        check("write_data", 32'(write_data), 32'(e_data[cyc]));
      end
      check("pkt_done", 32'(pkt_done), 32'(e_done[cyc]));
      check("pkt_error", 32'(pkt_error), 32'(e_err[cyc]));
      check("busy", 32'(busy), 32'(e_busy[cyc]));
      check("error_count", 32'(error_count), 32'(mec));
      if (write_en != '0) wlog.push_back('{cyc, write_en, write_addr, write_data});
      if (pkt_done) n_done++;
      if (pkt_error) n_err++;
    end
  end

  task automatic step(input bit r, input bit s, input logic [7:0] d, input bit i);
    @(negedge clk);
    reset = r; rx_strobe = s; rx_data = d; rx_idle = i;
    model(cyc, r, s, d, i);
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b0, 1'b1, b, 1'b0);
  endtask

  task automatic gap(input int n);
    for (int g = 0; g < n; g++) step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic idle_cyc();
    step(1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic fresh();
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    gap(2);
    #2;
    wlog.delete();
    n_done = 0;
    n_err = 0;
  endtask

  logic [7:0] pk[$];
  logic [7:0] hdr, fl;
  int         len, cut, sum;

  initial begin
    fresh();
    check("reset_write_en", 32'(write_en), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_error_count", 32'(error_count), 32'h0);
    check("reset_pkt_flags", 32'({pkt_done, pkt_error}), 32'h0);

`ifndef PSX_PKT_CHECKSUM_EN
    send(8'h51); send(8'h01); send(8'hAA); send(8'hBB); gap(3); #2;
    check("t1_nwrites", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      check("t1_write0", 32'({wlog[0].wen, wlog[0].a, wlog[0].d}), 32'({2'b10, 5'd0, 8'hAA}));
      check("t1_write1", 32'({wlog[1].wen, wlog[1].a, wlog[1].d}), 32'({2'b10, 5'd1, 8'hBB}));
    end
    check("t1_done", 32'(n_done), 32'd1);
    check("t1_error_count", 32'(error_count), 32'd0);

    fresh();
    send(8'h50); send(8'h04);
    for (int b = 0; b < 18; b++) send(8'(b));
    gap(3); #2;
    check("t2_nwrites", 32'(wlog.size()), 32'd18);
    foreach (wlog[n]) check("t2_addr_eq_data", 32'({wlog[n].wen, wlog[n].a}), 32'({2'b01, wlog[n].d[4:0]}));
    check("t2_done", 32'(n_done), 32'd1);

    fresh();
    send(8'h60); send(8'h01); send(8'hAA); send(8'hBB); idle_cyc(); send(8'h50); send(8'h00); gap(3); #2;
    check("t3_nwrites", 32'(wlog.size()), 32'd0);
    check("t3_errors", 32'(n_err), 32'd1);
    check("t3_done", 32'(n_done), 32'd1);
    check("t3_error_count", 32'(error_count), 32'd1);

    fresh();
    send(8'h50); send(8'h02); send(8'h11); send(8'h22); step(1'b0, 1'b1, 8'h33, 1'b1); gap(3); #2;
    check("t4_nwrites", 32'(wlog.size()), 32'd2);
    check("t4_errors", 32'(n_err), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_error_count", 32'(error_count), 32'd1);

    fresh();
    for (int p = 0; p < 256; p++) begin
      send(8'h53); send(8'h01); send(8'hAA); send(8'hBB);
    end
    gap(3); #2;
    check("t5_nwrites", 32'(wlog.size()), 32'd0);
    check("t5_errors", 32'(n_err), 32'd256);
    check("t5_error_count", 32'(error_count), 32'hFF);

    fresh();
    send(8'h50); send(8'h02); send(8'h11); step(1'b1, 1'b0, 8'h00, 1'b0); gap(3); #2;
    check("reset_mid_errors", 32'(n_err), 32'd0);
    check("reset_mid_done", 32'(n_done), 32'd0);
    check("reset_mid_busy", 32'(busy), 32'd0);
`else
    fresh();
    send(8'h50); send(8'h01); send(8'h10); send(8'h20); send(8'h7F); gap(4); #2;
    check("t6_nwrites", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      check("t6_write0", 32'({wlog[0].wen, wlog[0].a, wlog[0].d}), 32'({2'b01, 5'd0, 8'h10}));
      check("t6_write1", 32'({wlog[1].wen, wlog[1].a, wlog[1].d}), 32'({2'b01, 5'd1, 8'h20}));
      check("t6_back_to_back", 32'(wlog[1].c - wlog[0].c), 32'd1);
    end
    check("t6_done", 32'(n_done), 32'd1);

    fresh();
    send(8'h50); send(8'h01); send(8'h10); send(8'h20); send(8'h7E); gap(4); #2;
    check("t6_bad_nwrites", 32'(wlog.size()), 32'd0);
    check("t6_bad_errors", 32'(n_err), 32'd1);
    check("t6_bad_done", 32'(n_done), 32'd0);
`endif

    fresh();
    for (int p = 0; p < 300; p++) begin
      pk.delete();
      if ($urandom_range(0, 9) == 0) hdr = 8'($urandom_range(0, 255));
      else hdr = {4'h5, 4'($urandom_range(0, 3))};
      fl = 8'($urandom_range(0, 255));
      len = plen(fl);
      pk.push_back(hdr);
      pk.push_back(fl);
      sum = int'(hdr) + int'(fl);
      for (int b = 0; b < len; b++) begin
        pk.push_back(8'($urandom_range(0, 255)));
        sum += int'(pk[pk.size()-1]);
      end
      if (CKS) begin
        if ($urandom_range(0, 7) == 0) pk.push_back(8'($urandom_range(0, 255)));
        else pk.push_back(8'((256 - (sum % 256)) % 256));
      end
      cut = ($urandom_range(0, 9) == 0) ? $urandom_range(1, pk.size()) : pk.size() + 1;
      for (int b = 0; b < pk.size() && b < cut; b++) begin
        gap($urandom_range(0, 2));
        send(pk[b]);
      end
      if (cut <= pk.size()) idle_cyc();
      if (hdr[7:4] != 4'h5 || $urandom_range(0, 3) == 0) idle_cyc();
      gap($urandom_range(0, 2));
    end
    gap(30);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
